frame_stack: RTL and testbench
==============================

# frame_stack

Parametrised LIFO frame store for the recursive Fibonacci datapath. It pushes and pops multi-word call frames (for example n, return value and flag) on request from the main controller, one word per cycle. It owns the stack storage and pointer, reports full/empty and frame count, and flags overflow and underflow instead of corrupting state. It replaces a fixed three-word push/pop sequencer that had no storage bounds checking.

## Interface
- `DATA_W`, default 16: width of one stack word.
- `FRAME_WORDS`, default 3: words per frame, at least 1.
- `DEPTH`, default 48: storage depth in words. Must be a multiple of `FRAME_WORDS`.
- `PTR_W`, default `$clog2(DEPTH+1)`: width of the stack pointer and frame count.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `push_sig`  in  1  request to push `frame_in`.
- `pop_sig`  in  1  request to pop one frame to `frame_out`.
- `clr_sig`  in  1  request to empty the stack.
- `frame_in`  in  `FRAME_WORDS*DATA_W`  frame to push. Word k is bits `[k*DATA_W +: DATA_W]`.
- `frame_out`  out  `FRAME_WORDS*DATA_W`  last popped frame, same packing as `frame_in`.
- `ready`  out  1  high while in IDLE; requests are accepted only when high.
- `frame_valid`  out  1  one-cycle pulse when a popped frame is complete.
- `err_overflow`  out  1  one-cycle pulse: a push was rejected because the stack is full.
- `err_underflow`  out  1  one-cycle pulse: a pop was rejected because the stack is empty.
- `full`  out  1  fewer than `FRAME_WORDS` free words.
- `empty`  out  1  stack pointer is 0.
- `frame_count`  out  `PTR_W`  number of frames currently stored.

## Operation
- States: IDLE, PUSH, POP, DONE.
- Request priority, sampled only in IDLE: `clr_sig`, then `pop_sig`, then `push_sig`. Requests outside IDLE are ignored, not queued.
- IDLE with `clr_sig`:
  - stack pointer (sp) and `frame_count` go to 0; stays in IDLE.
  - `frame_out` is unchanged.
- IDLE with pop:
  - if empty: `err_underflow` pulses and state stays IDLE.
  - otherwise go to POP with word index `idx = FRAME_WORDS-1`.
- IDLE with push:
  - if full: `err_overflow` pulses and state stays IDLE.
  - otherwise latch `frame_in` internally and go to PUSH with `idx = 0`.
- PUSH, each cycle:
  - `mem[sp] <= word idx` of the latched frame; `sp++`; `idx++`.
  - after word `FRAME_WORDS-1`: `frame_count++` and go to DONE.
- POP, each cycle:
  - `frame_out` word idx `<= mem[sp-1]`; `sp--`; `idx--`.
  - after word 0: `frame_count--` and go to DONE.
  - Word order is reversed relative to push, so a popped frame equals the pushed frame.
- DONE: `frame_valid = 1` if the operation was a pop; next state IDLE.
- `full = (sp > DEPTH - FRAME_WORDS)`; `empty = (sp == 0)`. Both are combinational from sp.
- `frame_in` is latched at accept, so changes during PUSH have no effect.

## Timing
- Reset (`rst_n` low at an edge):
  - state IDLE, sp 0, `frame_count` 0, `frame_out` 0.
  - `frame_valid`, `err_overflow`, `err_underflow` all 0.
  - `ready` 1, `empty` 1, `full` 0.
  - Memory contents are unspecified and not observable.
- Reset mid-operation abandons the transfer. The partially written frame is discarded because sp returns to 0.
- Accept at edge E0; words move at E1..E_F (F = `FRAME_WORDS`); DONE during the cycle after E_F; IDLE after E_(F+1).
- `ready` is low for F+1 cycles after an accepted push or pop. The earliest next accept is E_(F+2).
- `frame_valid` is high for exactly one cycle, during DONE. `frame_out` stays stable from DONE until the next pop writes it.
- Error pulses are registered: high for the one cycle after the rejecting edge. `ready` stays high throughout.
- `clr_sig` takes one edge; `ready` never drops.

## Test plan
- Reset, then push frames {1,10,0} and {2,20,1} → after each push, `ready` is low for 4 cycles (F=3); `frame_count` = 2, `empty` = 0.
- Pop twice → `frame_valid` pulses each time. `frame_out` = {2,20,1}, then {1,10,0}. Then `empty` = 1 and `frame_count` = 0.
- Pop when empty → `err_underflow` is a 1-cycle pulse, `frame_out` is unchanged, `ready` stays 1.
- Push 16 frames with DEPTH = 48 → `full` = 1. A 17th push gives an `err_overflow` pulse and `frame_count` stays 16. Then pop all 16 and check LIFO order.
- Assert `push_sig`, `pop_sig` and `clr_sig` together on a non-empty stack → clear wins, `frame_count` = 0. Then `pop_sig` and `push_sig` together → pop wins (`err_underflow` pulses).
- Drive `rst_n` low at E2 of a push → next cycle `ready` = 1, `empty` = 1, `frame_count` = 0. A following pop gives `err_underflow`.

Source files
------------

// File: rtl/frame_stack.sv
// LIFO call-frame store: pushes and pops multi-word frames one word per cycle,
// with bounds checking that reports overflow/underflow instead of corrupting state.
module frame_stack #(
    parameter int DATA_W      = 16,
    parameter int FRAME_WORDS = 3,
    parameter int DEPTH       = 48,
    parameter int PTR_W       = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_sig,
    input  logic                          pop_sig,
    input  logic                          clr_sig,
    input  logic [FRAME_WORDS*DATA_W-1:0] frame_in,
    output logic [FRAME_WORDS*DATA_W-1:0] frame_out,
    output logic                          ready,
    output logic                          frame_valid,
    output logic                          err_overflow,
    output logic                          err_underflow,
    output logic                          full,
    output logic                          empty,
    output logic [PTR_W-1:0]              frame_count
);

    localparam int FW_BITS = FRAME_WORDS * DATA_W;
    localparam int IDX_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_WORDS - 1);
    localparam logic [PTR_W-1:0] FULL_TH  = PTR_W'(DEPTH - FRAME_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   sp_q, sp_d;
    logic [PTR_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FW_BITS-1:0] latch_q, latch_d;
    logic [FW_BITS-1:0] out_q, out_d;
    logic               was_pop_q, was_pop_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               mem_we;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  rd_word;
    logic [PTR_W-1:0]   sp_dec;

    assign sp_dec  = sp_q - PTR_W'(1);
    assign rd_word = mem_q[sp_dec[AW-1:0]];

    assign full          = (sp_q > FULL_TH);
    assign empty         = (sp_q == '0);
    assign ready         = (state_q == S_IDLE);
    assign frame_valid   = (state_q == S_DONE) && was_pop_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;
    assign frame_out     = out_q;
    assign frame_count   = count_q;

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        count_d   = count_q;
        idx_d     = idx_q;
        latch_d   = latch_q;
        out_d     = out_q;
        was_pop_d = was_pop_q;
        ovf_d     = 1'b0;
        udf_d     = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = latch_q[int'(idx_q)*DATA_W +: DATA_W];

        case (state_q)
            S_IDLE: begin
                if (clr_sig) begin
                    sp_d    = '0;
                    count_d = '0;
                end else if (pop_sig) begin
                    if (empty) begin
                        udf_d = 1'b1;
                    end else begin
                        state_d   = S_POP;
                        idx_d     = IDX_LAST;
                        was_pop_d = 1'b1;
                    end
                end else if (push_sig) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        latch_d   = frame_in;
                        state_d   = S_PUSH;
                        idx_d     = '0;
                        was_pop_d = 1'b0;
                    end
                end
            end
            S_PUSH: begin
                mem_we = 1'b1;
                sp_d   = sp_q + PTR_W'(1);
                if (idx_q == IDX_LAST) begin
                    count_d = count_q + PTR_W'(1);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_POP: begin
                // Words come off top-down, so the highest index is refilled first.
                out_d[int'(idx_q)*DATA_W +: DATA_W] = rd_word;
                sp_d = sp_dec;
                if (idx_q == '0) begin
                    count_d = count_q - PTR_W'(1);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sp_q      <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            latch_q   <= '0;
            out_q     <= '0;
            was_pop_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            latch_q   <= latch_d;
            out_q     <= out_d;
            was_pop_q <= was_pop_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage has no reset; contents above sp are never observable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[sp_q[AW-1:0]] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_frame_stack.sv
// Self-checking bench for frame_stack: directed table, corner-case sequences and
// randomized operations checked against a queue-based LIFO model.
module tb_frame_stack;

    localparam int DW    = 16;
    localparam int FW    = 3;
    localparam int DEPTH = 48;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int FB    = FW * DW;
    localparam int MAXF  = DEPTH / FW;

    logic          clk;
    logic          rst_n;
    logic          push_sig, pop_sig, clr_sig;
    logic [FB-1:0] frame_in;
    logic [FB-1:0] frame_out;
    logic          ready, frame_valid, err_overflow, err_underflow, full, empty;
    logic [PW-1:0] frame_count;

    frame_stack #(
        .DATA_W(DW),
        .FRAME_WORDS(FW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push_sig(push_sig),
        .pop_sig(pop_sig),
        .clr_sig(clr_sig),
        .frame_in(frame_in),
        .frame_out(frame_out),
        .ready(ready),
        .frame_valid(frame_valid),
        .err_overflow(err_overflow),
        .err_underflow(err_underflow),
        .full(full),
        .empty(empty),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [FB-1:0] stk[$];
    logic [FB-1:0] m_out;

    typedef struct {
        logic          c, p, u;
        logic [FB-1:0] fin;
        int            exp_count;
        logic          exp_empty;
        logic [FB-1:0] exp_out;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FB-1:0] mkf(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                          input logic [DW-1:0] w2);
        return {w2, w1, w0};
    endfunction

    function automatic logic [FB-1:0] rnd_frame();
        return FB'({$urandom(), $urandom()});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in IDLE and check the whole resulting handshake against the model.
    task automatic apply(input logic c, input logic p, input logic u, input logic [FB-1:0] fin);
        logic          is_xfer;
        logic          is_pop;
        logic [FB-1:0] popped;
        is_xfer = 1'b0;
        is_pop  = 1'b0;
        popped  = '0;
        clr_sig = c; pop_sig = p; push_sig = u; frame_in = fin;
        tick();
        clr_sig = 1'b0; pop_sig = 1'b0; push_sig = 1'b0; frame_in = rnd_frame();
        if (c) begin
            stk.delete();
            chk("clr_ready", 64'(ready), 64'(1));
            chk("clr_out", 64'(frame_out), 64'(m_out));
        end else if (p) begin
            if (stk.size() == 0) begin
                chk("udf_pulse", 64'(err_underflow), 64'(1));
                chk("udf_ready", 64'(ready), 64'(1));
                chk("udf_no_ovf", 64'(err_overflow), 64'(0));
                tick();
                chk("udf_end", 64'(err_underflow), 64'(0));
                chk("udf_out", 64'(frame_out), 64'(m_out));
            end else begin
                popped  = stk.pop_back();
                m_out   = popped;
                is_xfer = 1'b1;
                is_pop  = 1'b1;
            end
        end else if (u) begin
            if (stk.size() == MAXF) begin
                chk("ovf_pulse", 64'(err_overflow), 64'(1));
                chk("ovf_ready", 64'(ready), 64'(1));
                tick();
                chk("ovf_end", 64'(err_overflow), 64'(0));
            end else begin
                stk.push_back(fin);
                is_xfer = 1'b1;
            end
        end
        if (is_xfer) begin
            for (int i = 0; i < FW + 1; i++) begin
                if (i > 0) begin
                    frame_in = rnd_frame();
                    tick();
                end
                chk("busy_ready", 64'(ready), 64'(0));
                chk("frame_valid", 64'(frame_valid), 64'(is_pop && i == FW));
                if (is_pop && i == FW) chk("done_out", 64'(frame_out), 64'(popped));
            end
            tick();
            chk("idle_ready", 64'(ready), 64'(1));
            chk("idle_fv", 64'(frame_valid), 64'(0));
            if (is_pop) chk("pop_out", 64'(frame_out), 64'(popped));
        end
        chk("count", 64'(frame_count), 64'(stk.size()));
        chk("empty", 64'(empty), 64'(stk.size() == 0));
        chk("full", 64'(full), 64'(stk.size() == MAXF));
    endtask

    initial begin
        logic c, p, u;
        int   r;

        tbl[0] = '{1'b0, 1'b0, 1'b1, mkf(16'd1, 16'd10, 16'd0), 1, 1'b0, '0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, mkf(16'd2, 16'd20, 16'd1), 2, 1'b0, '0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, '0, 1, 1'b0, mkf(16'd2, 16'd20, 16'd1)};
        tbl[3] = '{1'b0, 1'b1, 1'b0, '0, 0, 1'b1, mkf(16'd1, 16'd10, 16'd0)};
        tbl[4] = '{1'b0, 1'b1, 1'b0, '0, 0, 1'b1, mkf(16'd1, 16'd10, 16'd0)};

        m_out = '0;
        rst_n = 1'b0;
        push_sig = 1'b0; pop_sig = 1'b0; clr_sig = 1'b0; frame_in = '0;
        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_count", 64'(frame_count), 64'(0));
        chk("rst_out", 64'(frame_out), 64'(0));
        chk("rst_fv", 64'(frame_valid), 64'(0));
        chk("rst_ovf", 64'(err_overflow), 64'(0));
        chk("rst_udf", 64'(err_underflow), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply(tbl[i].c, tbl[i].p, tbl[i].u, tbl[i].fin);
            chk("tbl_count", 64'(frame_count), 64'(tbl[i].exp_count));
            chk("tbl_empty", 64'(empty), 64'(tbl[i].exp_empty));
            chk("tbl_out", 64'(frame_out), 64'(tbl[i].exp_out));
        end

        // Fill to capacity, overflow, then drain in LIFO order.
        for (int i = 0; i < MAXF; i++) apply(1'b0, 1'b0, 1'b1, rnd_frame());
        chk("fill_full", 64'(full), 64'(1));
        apply(1'b0, 1'b0, 1'b1, rnd_frame());
        chk("ovf_count", 64'(frame_count), 64'(MAXF));
        for (int i = 0; i < MAXF; i++) apply(1'b0, 1'b1, 1'b0, '0);
        chk("drain_empty", 64'(empty), 64'(1));

        // Priority: clear over pop over push.
        apply(1'b0, 1'b0, 1'b1, rnd_frame());
        apply(1'b0, 1'b0, 1'b1, rnd_frame());
        apply(1'b1, 1'b1, 1'b1, rnd_frame());
        chk("prio_clr_count", 64'(frame_count), 64'(0));
        apply(1'b0, 1'b1, 1'b1, rnd_frame());

        // Reset asserted at the second edge of a push abandons the transfer.
        push_sig = 1'b1; frame_in = rnd_frame();
        tick();
        push_sig = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        stk.delete();
        m_out = '0;
        chk("mid_rst_ready", 64'(ready), 64'(1));
        chk("mid_rst_empty", 64'(empty), 64'(1));
        chk("mid_rst_count", 64'(frame_count), 64'(0));
        apply(1'b0, 1'b1, 1'b0, '0);

        // Randomized mix checked against the queue model.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            c = (r == 0);
            p = (r >= 1 && r <= 3) || (r == 0 && $urandom_range(0, 1) == 1);
            u = (r >= 4) || ($urandom_range(0, 3) == 0);
            apply(c, p, u, rnd_frame());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
